// File: rtl/fixed_lut_pkg.sv
// Shared constants, lane index type and table sizing helper for the
// shared activation lookup table arbiter.
package fixed_lut_pkg;

    localparam int DEFAULT_IN_WIDTH  = 8;
    localparam int DEFAULT_OUT_WIDTH = 8;
    localparam int DEFAULT_NUM_REQ   = 4;

    typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] lane_idx_t;

    function automatic int lutDepth(input int inWidth);
        return 1 << inWidth;
    endfunction

endpackage

// File: rtl/fixed_lut_arbiter_rr_grant.sv
// Combinational round-robin arbiter: the first eligible lane at or after
// the pointer wins. The pointer register lives in the parent.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [N-1:0]     eligible_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grantIdx_o,
    output logic             anyGrant_o
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] laneSum;
    logic [IDX_W-1:0] laneIdx;

    // Walk N positions from the pointer, wrapping modulo N.
    always_comb begin
        grant_o    = '0;
        grantIdx_o = '0;
        anyGrant_o = 1'b0;
        laneSum    = '0;
        laneIdx    = '0;
        for (int k = 0; k < N; k++) begin
            laneSum = {1'b0, ptr_i} + SUM_W'(k);
            if (laneSum >= SUM_W'(N)) begin
                laneSum = laneSum - SUM_W'(N);
            end
            laneIdx = laneSum[IDX_W-1:0];
            if (!anyGrant_o && eligible_i[laneIdx]) begin
                grant_o[laneIdx] = 1'b1;
                grantIdx_o       = laneIdx;
                anyGrant_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_lut_arbiter.sv
// Shared, run-time reprogrammable activation lookup table serving several
// requester lanes round-robin, one lookup per cycle, 1-cycle latency.
module fixed_lut_arbiter
    import fixed_lut_pkg::*;
#(
    parameter int    IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int    OUT_WIDTH = DEFAULT_OUT_WIDTH,
    parameter int    NUM_REQ   = DEFAULT_NUM_REQ,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  req_data [NUM_REQ],
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [OUT_WIDTH-1:0] resp_data [NUM_REQ],
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    input  logic                 cfg_wr_en,
    input  logic [IN_WIDTH-1:0]  cfg_wr_addr,
    input  logic [OUT_WIDTH-1:0] cfg_wr_data
);

    localparam int DEPTH = lutDepth(IN_WIDTH);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_REQ - 1);

    logic [OUT_WIDTH-1:0] lutMem [DEPTH];

    logic [IDX_W-1:0]     rrPtr_q, rrPtr_d;
    logic [NUM_REQ-1:0]   respValid_q, respValid_d;
    logic [OUT_WIDTH-1:0] respData_q [NUM_REQ];
    logic [OUT_WIDTH-1:0] respData_d [NUM_REQ];

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   handshake;
    logic [IDX_W-1:0]     grantIdx;
    logic                 anyGrant;
    logic [OUT_WIDTH-1:0] lookupData;

    // Table contents survive reset; only the config port changes them.
    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            lutMem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    assign eligible = req_valid & (~respValid_q | resp_ready);

    rr_grant #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .ptr_i      (rrPtr_q),
        .eligible_i (eligible),
        .grant_o    (grant),
        .grantIdx_o (grantIdx),
        .anyGrant_o (anyGrant)
    );

    // A pending config write blocks grants, so reads never race the write.
    assign handshake  = grant & {NUM_REQ{~cfg_wr_en & ~rst}};
    assign req_ready  = handshake;
    assign lookupData = lutMem[req_data[grantIdx]];

    always_comb begin
        rrPtr_d     = rrPtr_q;
        respValid_d = respValid_q;
        respData_d  = respData_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (handshake[i]) begin
                respValid_d[i] = 1'b1;
                respData_d[i]  = lookupData;
            end else if (resp_ready[i]) begin
                respValid_d[i] = 1'b0;
            end
        end
        if (anyGrant && (|handshake)) begin
            rrPtr_d = (grantIdx == LAST_LANE) ? '0 : grantIdx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr_q     <= '0;
            respValid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                respData_q[i] <= '0;
            end
        end else begin
            rrPtr_q     <= rrPtr_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
        end
    end

    assign resp_valid = respValid_q;
    assign resp_data  = respData_q;

endmodule

// File: tb/tb_fixed_lut_arbiter.sv
// Randomized plus directed bench for fixed_lut_arbiter against a
// behavioural model of the shared table, response slots and rotation.
module tb_fixed_lut_arbiter;
    import fixed_lut_pkg::*;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    reqData [NR];
    logic [NR-1:0] reqValid, reqReady, respValid, respReady;
    logic [7:0]    respData [NR];
    logic          cfgWrEn;
    logic [7:0]    cfgWrAddr, cfgWrData;

    int checks = 0;
    int passes = 0;

    logic [7:0]    mTable [256];
    bit            mValid [NR];
    logic [7:0]    mData  [NR];
    int            mPtr;
    logic [NR-1:0] lastReady;
    lane_idx_t     seenLane;

    always #5 clk = ~clk;

    fixed_lut_arbiter #(
        .IN_WIDTH  (8),
        .OUT_WIDTH (8),
        .NUM_REQ   (NR),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (reqData),
        .req_valid   (reqValid),
        .req_ready   (reqReady),
        .resp_data   (respData),
        .resp_valid  (respValid),
        .resp_ready  (respReady),
        .cfg_wr_en   (cfgWrEn),
        .cfg_wr_addr (cfgWrAddr),
        .cfg_wr_data (cfgWrData)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            mValid[i] = 1'b0;
            mData[i]  = 8'h00;
        end
        mPtr = 0;
    endtask

    // Lane the rules say must be granted now, or -1.
    function automatic int modelGrant();
        if (rst || cfgWrEn) return -1;
        for (int k = 0; k < NR; k++) begin
            int l = (mPtr + k) % NR;
            if (reqValid[l] && (!mValid[l] || respReady[l])) return l;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] r,
                                 input logic we, input logic [7:0] wa, input logic [7:0] wd);
        reqValid  = v;
        respReady = r;
        cfgWrEn   = we;
        cfgWrAddr = wa;
        cfgWrData = wd;
    endtask

    task automatic checkOutput();
        int g;
        logic [NR-1:0] expReady;
        logic [NR-1:0] expValid;
        g = modelGrant();
        expReady = (g >= 0) ? (4'(1) << g) : 4'(0);
        for (int i = 0; i < NR; i++) expValid[i] = mValid[i];
        lastReady = reqReady;
        checkVal("req_ready", 32'(reqReady), 32'(expReady));
        checkVal("resp_valid", 32'(respValid), 32'(expValid));
        for (int i = 0; i < NR; i++) begin
            if (mValid[i]) checkVal($sformatf("resp_data[%0d]", i), 32'(respData[i]), 32'(mData[i]));
        end
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic stepCycle();
        int g;
        #1;
        checkOutput();
        g = modelGrant();
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (respReady[i]) mValid[i] = 1'b0;
        if (g >= 0) begin
            mValid[g] = 1'b1;
            mData[g]  = mTable[reqData[g]];
            mPtr      = (g + 1) % NR;
        end
        if (cfgWrEn) mTable[cfgWrAddr] = cfgWrData;
        @(negedge clk);
    endtask

    task automatic pulseReset();
        applyStimulus('0, '1, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int found;
        int others;
        logic [NR-1:0] seq [5];

        rst = 1'b1;
        for (int i = 0; i < NR; i++) reqData[i] = 8'h00;
        applyStimulus('0, '0, 1'b0, 8'h00, 8'h00);
        modelReset();
        #12;
        checkVal("reset resp_valid", 32'(respValid), 32'h0);
        checkVal("reset req_ready", 32'(reqReady), 32'h0);
        checkVal("reset resp_data0", 32'(respData[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 256; a++) begin
            applyStimulus('0, '1, 1'b1, 8'(a), 8'(a) ^ 8'hFF);
            stepCycle();
        end

        // Single lookup, latency one cycle.
        reqData[0] = 8'h10;
        applyStimulus(4'b0001, 4'b1111, 1'b0, 8'h00, 8'h00);
        stepCycle();
        checkVal("t1 req_ready", 32'(lastReady), 32'h1);
        checkVal("t1 resp_valid0", 32'(respValid[0]), 32'h1);
        checkVal("t1 resp_data0", 32'(respData[0]), 32'hEF);

        // Rotation 0,1,2,3,0 from a fresh pointer.
        pulseReset();
        for (int i = 0; i < NR; i++) reqData[i] = 8'h20 + 8'(i);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            seq[c] = lastReady;
            if (c == 2) checkVal("t2 resp_data2", 32'(respData[2]), 32'hDD);
            if (c == 3) checkVal("t2 resp_data3", 32'(respData[3]), 32'hDC);
        end
        checkVal("t2 grant0", 32'(seq[0]), 32'h1);
        checkVal("t2 grant1", 32'(seq[1]), 32'h2);
        checkVal("t2 grant2", 32'(seq[2]), 32'h4);
        checkVal("t2 grant3", 32'(seq[3]), 32'h8);
        checkVal("t2 grant4", 32'(seq[4]), 32'h1);

        // Stalled lane 2 is skipped, then resumes.
        found = 0;
        for (int c = 0; c < NR && found == 0; c++) begin
            stepCycle();
            if (lastReady[2]) found = 1;
        end
        checkVal("t3 lane2 first grant", 32'(found), 32'h1);
        applyStimulus(4'b1111, 4'b1011, 1'b0, 8'h00, 8'h00);
        others = 0;
        for (int c = 0; c < 8; c++) begin
            stepCycle();
            if (lastReady[2]) checkVal("t3 lane2 stalled grant", 32'(lastReady[2]), 32'h0);
            if (lastReady != 4'b0000) others++;
            checkVal("t3 resp_data2 held", 32'(respData[2]), 32'hDD);
        end
        checkVal("t3 other lanes served", 32'(others), 32'h8);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 8'h00, 8'h00);
        found = 0;
        for (int c = 0; c < NR && found == 0; c++) begin
            stepCycle();
            if (lastReady[2]) begin
                found    = 1;
                seenLane = lane_idx_t'(2);
            end
        end
        checkVal("t3 lane2 resumed", 32'(found), 32'h1);

        // Drain and refill on the same lane.
        applyStimulus('0, '1, 1'b0, 8'h00, 8'h00);
        stepCycle();
        reqData[0] = 8'h10;
        applyStimulus(4'b0001, 4'b0000, 1'b0, 8'h00, 8'h00);
        stepCycle();
        checkVal("t5 slot EF", 32'(respData[0]), 32'hEF);
        reqData[0] = 8'h00;
        applyStimulus(4'b0001, 4'b0001, 1'b0, 8'h00, 8'h00);
        stepCycle();
        checkVal("t5 refill ready", 32'(lastReady), 32'h1);
        checkVal("t5 resp_valid0", 32'(respValid[0]), 32'h1);
        checkVal("t5 resp_data0", 32'(respData[0]), 32'hFF);

        // Config write blocks a same-cycle grant.
        applyStimulus('0, '1, 1'b0, 8'h00, 8'h00);
        stepCycle();
        reqData[1] = 8'h10;
        applyStimulus(4'b0010, 4'b1111, 1'b1, 8'h10, 8'h55);
        stepCycle();
        checkVal("t4 blocked", 32'(lastReady), 32'h0);
        applyStimulus(4'b0010, 4'b1111, 1'b0, 8'h00, 8'h00);
        stepCycle();
        checkVal("t4 granted", 32'(lastReady), 32'h2);
        checkVal("t4 resp_data1", 32'(respData[1]), 32'h55);

        // Asynchronous reset with three full slots.
        applyStimulus(4'b0111, 4'b0000, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 3; c++) stepCycle();
        checkVal("t6 slots full", 32'(respValid), 32'h7);
        rst = 1'b1;
        #1;
        checkVal("t6 async resp_valid", 32'(respValid), 32'h0);
        checkVal("t6 async req_ready", 32'(reqReady), 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        reqData[0] = 8'h10;
        applyStimulus(4'b1111, 4'b1111, 1'b0, 8'h00, 8'h00);
        stepCycle();
        checkVal("t6 pointer zero", 32'(lastReady), 32'h1);
        checkVal("t6 table kept", 32'(respData[0]), 32'h55);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) reqData[i] = 8'($urandom);
            applyStimulus(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0),
                          8'($urandom), 8'($urandom));
            stepCycle();
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
